// File: rtl/elevator_controller.sv
`default_nettype none
// ============================================================================
// Module      : elevator_controller
// Description : Single-car elevator controller. Latches per-floor calls,
//               services them with a direction-preferring scan, and times
//               floor travel and door dwell from a synchronised slow tick.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_controller #(
    parameter int N_FLOORS     = 4,
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 5
) (
    input  logic                        clk50,
    input  logic                        reset,
    input  logic                        div_clk,
    input  logic [N_FLOORS-1:0]         call_req,
    output logic [$clog2(N_FLOORS)-1:0] current_floor,
    output logic                        moving_up,
    output logic                        moving_down,
    output logic                        door_open,
    output logic [N_FLOORS-1:0]         pending
);

    localparam int FW   = $clog2(N_FLOORS);
    localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    localparam logic [FW-1:0] C_TOP_FLOOR = FW'(N_FLOORS - 1);
    localparam logic [FW-1:0] C_GROUND    = '0;
    localparam logic [CW-1:0] C_TRAVEL    = CW'(TRAVEL_TICKS);
    localparam logic [CW-1:0] C_DOOR      = CW'(DOOR_TICKS);
    localparam logic [CW-1:0] C_CNT_MAX   = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    state_t              r_state, w_state_n;
    logic [FW-1:0]       r_floor, w_floor_n, w_step_floor;
    logic [N_FLOORS-1:0] r_pending, w_pending_n, w_set, w_clr;
    logic [CW-1:0]       r_cnt, w_cnt_n, w_cnt_inc;
    logic                r_dir_up, w_dir_up_n;
    logic                r_sync1, r_sync2, r_sync_prev;
    logic                w_tick;
    logic                w_above_cur, w_below_cur, w_above_step, w_below_step;

    // Two-flop synchroniser for div_clk plus one delay flop for edge detection
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync1     <= div_clk;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_tick = r_sync2 & ~r_sync_prev;

    // Saturating tick counter increment
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CW'(1);

    // Floor the car reaches when the current travel segment completes;
    // clamped so the car can never leave the shaft
    always_comb begin
        w_step_floor = r_floor;
        if (r_state == MOVE_UP && r_floor != C_TOP_FLOOR) begin
            w_step_floor = r_floor + FW'(1);
        end else if (r_state == MOVE_DOWN && r_floor != C_GROUND) begin
            w_step_floor = r_floor - FW'(1);
        end
    end

    // Pending calls above/below the current floor and the arrival floor
    always_comb begin
        w_above_cur  = 1'b0;
        w_below_cur  = 1'b0;
        w_above_step = 1'b0;
        w_below_step = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (r_pending[i]) begin
                if (i > int'(r_floor))      w_above_cur  = 1'b1;
                if (i < int'(r_floor))      w_below_cur  = 1'b1;
                if (i > int'(w_step_floor)) w_above_step = 1'b1;
                if (i < int'(w_step_floor)) w_below_step = 1'b1;
            end
        end
    end

    // Next-state, next-floor, counter, direction and pending-call logic
    always_comb begin
        w_state_n  = r_state;
        w_floor_n  = r_floor;
        w_cnt_n    = r_cnt;
        w_dir_up_n = r_dir_up;
        w_set      = call_req;
        w_clr      = '0;

        // A call at the floor whose door is already open is absorbed; it only
        // holds the door longer (handled below)
        if (r_state == DOOR_OPEN) begin
            w_set[r_floor] = 1'b0;
        end

        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (r_pending[r_floor]) begin
                    w_state_n      = DOOR_OPEN;
                    w_clr[r_floor] = 1'b1;
                end else if (w_above_cur && (r_dir_up || !w_below_cur)) begin
                    w_state_n  = MOVE_UP;
                    w_dir_up_n = 1'b1;
                end else if (w_below_cur) begin
                    w_state_n  = MOVE_DOWN;
                    w_dir_up_n = 1'b0;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (w_tick) begin
                    if (w_cnt_inc >= C_TRAVEL) begin
                        w_floor_n = w_step_floor;
                        w_cnt_n   = '0;
                        if (r_pending[w_step_floor]) begin
                            w_state_n           = DOOR_OPEN;
                            w_clr[w_step_floor] = 1'b1;
                        end else if ((r_state == MOVE_UP) ? !w_above_step : !w_below_step) begin
                            w_state_n = IDLE;
                        end
                    end else begin
                        w_cnt_n = w_cnt_inc;
                    end
                end
            end

            DOOR_OPEN: begin
                if (call_req[r_floor]) begin
                    w_cnt_n = '0;
                end else if (w_tick) begin
                    if (w_cnt_inc >= C_DOOR) begin
                        w_state_n = IDLE;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = w_cnt_inc;
                    end
                end
            end

            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase

        // Clearing wins over a same-cycle call: the opening door serves it
        w_pending_n = (r_pending | w_set) & ~w_clr;
    end

    // State and datapath registers
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state   <= IDLE;
            r_floor   <= '0;
            r_pending <= '0;
            r_cnt     <= '0;
            r_dir_up  <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_floor   <= w_floor_n;
            r_pending <= w_pending_n;
            r_cnt     <= w_cnt_n;
            r_dir_up  <= w_dir_up_n;
        end
    end

    assign current_floor = r_floor;
    assign pending       = r_pending;
    assign moving_up     = (r_state == MOVE_UP);
    assign moving_down   = (r_state == MOVE_DOWN);
    assign door_open     = (r_state == DOOR_OPEN);

endmodule
`default_nettype wire

// File: tb/tb_elevator_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_controller
// Description : Self-checking bench for elevator_controller with a
//               behavioural car model and directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_controller;

    localparam int NF = 4;
    localparam int TT = 3;
    localparam int DT = 5;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DN   = 2;
    localparam int M_DOOR = 3;

    logic       clk50    = 1'b0;
    logic       reset    = 1'b1;
    logic       div_clk  = 1'b0;
    logic [3:0] call_req = 4'b0;
    logic [1:0] current_floor;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic [3:0] pending;

    int errors = 0;
    int checks = 0;
    int divcnt = 0;
    int divper = 10;

    // Behavioural model of the car
    int       m_floor = 0;
    int       m_mode  = M_IDLE;
    int       m_cnt   = 0;
    bit       m_dir   = 1'b1;
    bit [3:0] m_pend  = 4'b0;
    bit       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    elevator_controller #(
        .N_FLOORS    (NF),
        .TRAVEL_TICKS(TT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk50        (clk50),
        .reset        (reset),
        .div_clk      (div_clk),
        .call_req     (call_req),
        .current_floor(current_floor),
        .moving_up    (moving_up),
        .moving_down  (moving_down),
        .door_open    (door_open),
        .pending      (pending)
    );

    always #5 clk50 = ~clk50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Drive one cycle of inputs; returns at the following falling edge
    task automatic cyc(input logic [3:0] c);
        call_req = c;
        div_clk  = (divcnt < divper / 2) ? 1'b1 : 1'b0;
        divcnt   = (divcnt + 1 >= divper) ? 0 : divcnt + 1;
        @(negedge clk50);
    endtask

    task automatic check_idle_at(input string name, input int fl);
        check({name, "_floor"}, 32'(current_floor), 32'(fl));
        check({name, "_status"}, 32'({moving_up, moving_down, door_open}), 32'd0);
        check({name, "_pending"}, 32'(pending), 32'd0);
    endtask

    // Model update and comparison after every rising edge
    always @(posedge clk50) begin : cmp
        bit       tk;
        bit       rs;
        bit       up_any;
        bit       dn_any;
        bit       fur;
        bit [3:0] set;
        bit [3:0] np;
        #1;
        if (reset) begin
            m_floor = 0;
            m_mode  = M_IDLE;
            m_cnt   = 0;
            m_dir   = 1'b1;
            m_pend  = 4'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            // tick seen at this edge: div_clk rose between samples 3 and 2 edges back
            tk = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = div_clk;
            set = call_req;
            rs  = 1'b0;
            if (m_mode == M_DOOR && call_req[m_floor]) begin
                set[m_floor] = 1'b0;
                rs = 1'b1;
            end
            np = m_pend | set;
            up_any = 1'b0;
            dn_any = 1'b0;
            for (int i = 0; i < NF; i++) begin
                if (m_pend[i] && i > m_floor) up_any = 1'b1;
                if (m_pend[i] && i < m_floor) dn_any = 1'b1;
            end
            case (m_mode)
                M_IDLE: begin
                    if (m_pend[m_floor]) begin
                        m_mode = M_DOOR; m_cnt = 0; np[m_floor] = 1'b0;
                    end else if (up_any && (m_dir || !dn_any)) begin
                        m_mode = M_UP; m_dir = 1'b1; m_cnt = 0;
                    end else if (dn_any) begin
                        m_mode = M_DN; m_dir = 1'b0; m_cnt = 0;
                    end
                end
                M_UP, M_DN: begin
                    if (tk) begin
                        m_cnt++;
                        if (m_cnt == TT) begin
                            m_cnt = 0;
                            m_floor += (m_mode == M_UP) ? 1 : -1;
                            fur = 1'b0;
                            for (int i = 0; i < NF; i++) begin
                                if (m_pend[i] && ((m_mode == M_UP && i > m_floor) ||
                                                  (m_mode == M_DN && i < m_floor)))
                                    fur = 1'b1;
                            end
                            if (m_pend[m_floor]) begin
                                m_mode = M_DOOR; np[m_floor] = 1'b0;
                            end else if (!fur) begin
                                m_mode = M_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    if (rs) m_cnt = 0;
                    else if (tk) begin
                        m_cnt++;
                        if (m_cnt == DT) begin
                            m_mode = M_IDLE; m_cnt = 0;
                        end
                    end
                end
            endcase
            m_pend = np;
        end
        check("m_floor", 32'(current_floor), 32'(m_floor));
        check("m_pending", 32'(pending), 32'(m_pend));
        check("m_moving_up", 32'(moving_up), (m_mode == M_UP) ? 32'd1 : 32'd0);
        check("m_moving_down", 32'(moving_down), (m_mode == M_DN) ? 32'd1 : 32'd0);
        check("m_door_open", 32'(door_open), (m_mode == M_DOOR) ? 32'd1 : 32'd0);
    end

    // Directed scenarios followed by randomized traffic
    initial begin : stim
        int n;
        int seg;
        @(negedge clk50);
        reset = 1'b1;
        cyc(4'b0);
        cyc(4'b0);
        check_idle_at("reset", 0);
        reset = 1'b0;
        cyc(4'b0);
        check_idle_at("post_reset", 0);

        // Call at the current floor while idle
        cyc(4'b0001);
        check("own_call_pending", 32'(pending), 32'd1);
        check("own_call_door_early", 32'(door_open), 32'd0);
        cyc(4'b0);
        check("own_call_door", 32'(door_open), 32'd1);
        check("own_call_cleared", 32'(pending), 32'd0);
        n = 0;
        while (door_open && n < 200) begin cyc(4'b0); n++; end
        check_range("own_call_door_cycles", n, 41, 50);
        check_idle_at("own_call_done", 0);

        // Travel from floor 0 to floor 2
        cyc(4'b0100);
        cyc(4'b0);
        check("up_start", 32'(moving_up), 32'd1);
        n = 0;
        while (current_floor == 2'd0 && n < 100) begin cyc(4'b0); n++; end
        check("up_floor1", 32'(current_floor), 32'd1);
        check("up_floor1_moving", 32'(moving_up), 32'd1);
        n = 0;
        while (current_floor == 2'd1 && n < 100) begin cyc(4'b0); n++; end
        check("up_floor_gap_cycles", 32'(n), 32'd30);
        check("up_floor2", 32'(current_floor), 32'd2);
        check("up_floor2_door", 32'(door_open), 32'd1);
        check("up_floor2_pending", 32'(pending), 32'd0);

        // Re-call at the open door's floor restarts the dwell
        repeat (30) cyc(4'b0);
        check("hold_door_before", 32'(door_open), 32'd1);
        cyc(4'b0100);
        check("hold_no_pending", 32'(pending), 32'd0);
        check("hold_door_still", 32'(door_open), 32'd1);
        n = 0;
        while (door_open && n < 200) begin cyc(4'b0); n++; end
        check_range("hold_door_cycles", n, 41, 50);
        check_idle_at("hold_done", 2);

        // Upward trip to floor 3 is finished before the floor-0 call
        reset = 1'b1;
        cyc(4'b0);
        reset = 1'b0;
        cyc(4'b1000);
        n = 0;
        while (current_floor != 2'd1 && n < 200) begin cyc(4'b0); n++; end
        check("sweep_at_floor1", 32'(moving_up), 32'd1);
        cyc(4'b0001);
        n = 0;
        while (!door_open && n < 300) begin cyc(4'b0); n++; end
        check("sweep_first_stop", 32'(current_floor), 32'd3);
        check("sweep_first_pending", 32'(pending), 32'd1);
        n = 0;
        while (!moving_down && n < 300) begin cyc(4'b0); n++; end
        check("sweep_reverse", 32'(moving_down), 32'd1);
        n = 0;
        while (!door_open && n < 400) begin cyc(4'b0); n++; end
        check("sweep_second_stop", 32'(current_floor), 32'd0);
        check("sweep_second_pending", 32'(pending), 32'd0);

        // Reset mid-travel leaves nothing behind
        reset = 1'b1;
        cyc(4'b0);
        reset = 1'b0;
        cyc(4'b1000);
        n = 0;
        while (current_floor != 2'd1 && n < 200) begin cyc(4'b0); n++; end
        repeat (5) cyc(4'b0);
        check("abort_moving", 32'(moving_up), 32'd1);
        check("abort_pending_before", 32'(pending), 32'b1000);
        reset = 1'b1;
        cyc(4'b0);
        reset = 1'b0;
        check_idle_at("abort", 0);
        repeat (20) cyc(4'b0);
        check_idle_at("abort_settled", 0);

        // Randomized traffic with varying divider periods and rare resets
        for (seg = 0; seg < 8; seg++) begin
            divper = $urandom_range(2, 14);
            divcnt = 0;
            for (int k = 0; k < 600; k++) begin
                reset = ($urandom_range(0, 799) == 0);
                if ($urandom_range(0, 7) == 0) cyc(4'($urandom_range(1, 15)));
                else cyc(4'b0);
            end
        end
        reset = 1'b0;
        cyc(4'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
